branch_resolve_queue: RTL
=========================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning branch PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 8 (power of two), meaning the number of in-flight branch entries.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port pred_valid  input  1  meaning the fetch stage presents a predicted branch.
REQ-006 SHALL have port pred_pc  input  PC_W  meaning the PC of the predicted branch.
REQ-007 SHALL have port pred_taken  input  1  meaning the predicted direction.
REQ-008 SHALL have port pred_ready  output  1  meaning the queue accepts an entry this cycle.
REQ-009 SHALL have port res_valid  input  1  meaning execute resolves the oldest in-flight branch.
REQ-010 SHALL have port res_taken  input  1  meaning the actual direction.
REQ-011 SHALL have port upd_valid  output  1  meaning a one-cycle predictor-update strobe.
REQ-012 SHALL have port upd_pc  output  PC_W  meaning the PC to update in the predictor tables.
REQ-013 SHALL have port upd_taken  output  1  meaning the outcome bit to shift into history and counters.
REQ-014 SHALL have port mispredict  output  1  meaning a one-cycle flush request, aligned with upd_valid.
REQ-015 SHALL have port res_err  output  1  meaning a one-cycle pulse when res_valid arrives while the queue is empty.
REQ-016 SHALL have port occupancy  output  $clog2(DEPTH)+1  meaning the current entry count.
REQ-017 SHALL have port miss_count  output  16  meaning the saturating mispredict total.

Function
REQ-018 SHALL enqueue {pred_pc, pred_taken} at the tail on a rising edge when pred_valid and pred_ready are both high.
REQ-019 SHALL drive pred_ready = (occupancy != DEPTH) combinationally; pred_valid while full is dropped with no state change.
REQ-020 SHALL retire the head entry on a rising edge when res_valid is high and occupancy != 0; resolution is strictly in order.
REQ-021 SHALL register the update one cycle after retirement: upd_valid=1, upd_pc=head PC, upd_taken=res_taken, mispredict=(res_taken != head predicted bit).
REQ-022 SHALL, on a mispredicting retirement, discard all remaining entries and any same-cycle enqueue, so that occupancy becomes 0 on that edge.
REQ-023 SHALL, on simultaneous enqueue and correctly-predicted retirement, leave occupancy unchanged (with the full condition evaluated before the edge); this holds for DEPTH=1 as well.
REQ-024 SHALL ignore res_valid when empty, with no update and no pointer change, and pulse res_err one cycle later.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH; occupancy SHALL distinguish full from empty.
REQ-026 SHALL increment miss_count by one per mispredict strobe and saturate at 16'hFFFF.
REQ-027 SHALL hold upd_valid, mispredict and res_err low in every cycle without a qualifying event.

Reset
REQ-028 SHALL, on reset low, immediately clear the pointers, occupancy, miss_count, upd_valid, upd_pc, upd_taken, mispredict and res_err to 0, regardless of the clock.
REQ-029 SHALL drop in-flight entries when reset asserts mid-operation; no update SHALL be emitted for them after reset releases.
REQ-030 SHALL leave entry storage contents unreset; entries are validated only by occupancy.

Structure
REQ-031 SHALL take PC_W, DEPTH defaults and the entry struct {pc, taken} from shared package bp_pkg.
REQ-032 SHALL use one sub-module, bp_entry_fifo (storage, pointers, occupancy, synchronous flush); compare, update and counter logic stay in the top level.

Verification
REQ-033 SHALL cover: enqueue PC 10'h005 predicted taken, resolve taken -> next cycle upd_valid=1, upd_pc=10'h005, upd_taken=1, mispredict=0.
REQ-034 SHALL cover: enqueue 10'h010/NT, 10'h011/T, 10'h012/T, then resolve head taken -> upd_pc=10'h010, mispredict=1, occupancy=0, miss_count=1.
REQ-035 SHALL cover: fill 8 entries -> pred_ready=0; a 9th pred_valid is dropped; simultaneous resolve and enqueue at full -> occupancy stays 8.
REQ-036 SHALL cover: res_valid with queue empty -> res_err pulse for 1 cycle, upd_valid=0.
REQ-037 SHALL cover: reset asserted with 3 entries queued -> all outputs 0 at once; after release, resolve -> res_err=1.
REQ-038 SHALL cover: 16 enqueue/retire cycles with pointer wrap -> updates in FIFO order with matching PCs.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default sizes and the in-flight entry layout.
package bp_pkg;

  localparam int unsigned BP_PC_W  = 10;
  localparam int unsigned BP_DEPTH = 8;

  // One in-flight branch: its PC and the direction fetch predicted.
  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
  } bp_entry_t;

  // Pointer width that stays legal for a single-entry queue.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bp_entry_fifo.sv
// Circular entry store for in-flight branches with occupancy tracking and a synchronous flush.
// The caller guarantees pop only when non-empty and push only when not full or popping.
module bp_entry_fifo
  import bp_pkg::*;
#(
  parameter  int unsigned DEPTH = BP_DEPTH,
  localparam int unsigned PtrW  = ptr_width(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  bp_entry_t       push_data,
  input  logic            pop,
  input  logic            flush,
  output bp_entry_t       head,
  output logic [CntW-1:0] occupancy,
  output logic            full,
  output logic            empty
);

  bp_entry_t       mem [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  assign head      = mem[head_q];
  assign occupancy = cnt_q;
  assign full      = (cnt_q == CntW'(DEPTH));
  assign empty     = (cnt_q == '0);

  // Next pointers and count; flush empties the queue regardless of push/pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop) begin
        head_d = (head_q == LastPtr) ? '0 : head_q + 1'b1;
      end
      if (push) begin
        tail_d = (tail_q == LastPtr) ? '0 : tail_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[tail_q] <= push_data;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: holds predicted branches from fetch, compares each against
// the execute outcome, and emits registered predictor-update and flush strobes.
// PC_W must match the entry layout in bp_pkg.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter  int unsigned PC_W  = BP_PC_W,
  parameter  int unsigned DEPTH = BP_DEPTH,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_taken,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic            upd_taken,
  output logic            mispredict,
  output logic            res_err,
  output logic [CntW-1:0] occupancy,
  output logic [15:0]     miss_count
);

  bp_entry_t head, push_data;
  logic      fifo_full, fifo_empty;
  logic      retire, miss, push;

  logic            upd_valid_q, upd_taken_q, mispredict_q, res_err_q;
  logic [PC_W-1:0] upd_pc_q;
  logic [15:0]     miss_count_q;

  assign pred_ready = ~fifo_full;

  // Retirement decode. At full, a correctly predicted retirement frees the head slot on the same
  // edge, so a waiting branch is taken and occupancy holds; a mispredict discards everything.
  always_comb begin
    retire          = res_valid & ~fifo_empty;
    miss            = retire & (res_taken != head.taken);
    push            = pred_valid & ~miss & (~fifo_full | retire);
    push_data.pc    = pred_pc;
    push_data.taken = pred_taken;
  end

  bp_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (retire),
    .flush     (miss),
    .head      (head),
    .occupancy (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Registered update/flush/error strobes, one cycle after the resolving edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      upd_valid_q  <= retire;
      mispredict_q <= miss;
      res_err_q    <= res_valid & fifo_empty;
      if (retire) begin
        upd_pc_q    <= head.pc;
        upd_taken_q <= res_taken;
      end
    end
  end

  // Saturating mispredict total, advancing together with the mispredict strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_count_q <= '0;
    end else if (miss && (miss_count_q != 16'hFFFF)) begin
      miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign upd_valid  = upd_valid_q;
  assign upd_pc     = upd_pc_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispredict_q;
  assign res_err    = res_err_q;
  assign miss_count = miss_count_q;

endmodule
